// File: rtl/cic_sample_sequencer.sv
// Captures one CIC sample per decimated period into a small FIFO during an armed window
// and streams each sample out MSB-first as bytes over a valid/ready handshake.
module cic_sample_sequencer #(
   parameter int unsigned DATA_WIDTH  = 20,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   cic_clk_i,
   input  logic [DATA_WIDTH-1:0]  sample_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic [COUNT_WIDTH-1:0] capture_count_i,
   output logic [7:0]             byte_o,
   output logic                   byte_valid_o,
   input  logic                   byte_ready_i,
   output logic                   busy_o,
   output logic                   overflow_o,
   output logic                   done_o
);

   localparam int unsigned NB  = (DATA_WIDTH + 7) / 8;
   localparam int unsigned SW  = NB * 8;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;

   logic [1:0]             state_q, state_d;
   logic                   cic_prev_q;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d, edge_cnt_inc;
   logic                   overflow_q, overflow_d;

   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                   fifo_empty, fifo_full;

   logic [SW-1:0]          shift_q, shift_d;
   logic [BCW-1:0]         bytes_left_q, bytes_left_d;
   logic                   byte_valid_q, byte_valid_d;

   logic edge_det, cap_edge, push, pop, drop, hit, xfer, last_byte, ser_free, done;

   assign edge_det     = cic_clk_i & ~cic_prev_q;
   assign cap_edge     = (state_q == CAPTURE) & edge_det;
   assign edge_cnt_inc = edge_cnt_q + COUNT_WIDTH'(1);

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign xfer      = byte_valid_q & byte_ready_i;
   assign last_byte = (bytes_left_q == '0);
   // The serializer can take a new sample when idle or finishing its last byte this cycle.
   assign ser_free  = ~byte_valid_q | (xfer & last_byte);
   assign pop       = ser_free & ~fifo_empty;
   assign push      = cap_edge & (~fifo_full | pop);
   assign drop      = cap_edge & ~push;
   assign hit       = cap_edge && (count_q != '0) && (edge_cnt_inc == count_q);
   assign done      = (state_q == DRAIN) && fifo_empty && ~byte_valid_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      edge_cnt_d = edge_cnt_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               count_d    = capture_count_i;
               edge_cnt_d = '0;
               overflow_d = 1'b0;
               state_d    = CAPTURE;
            end
         end
         CAPTURE: begin
            if (edge_det) edge_cnt_d = edge_cnt_inc;
            if (drop)     overflow_d = 1'b1;
            if (hit || stop_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d      = shift_q;
      bytes_left_d = bytes_left_q;
      byte_valid_d = byte_valid_q;
      if (pop) begin
         shift_d      = SW'(mem_q[rd_ptr_q[AW-1:0]]);
         bytes_left_d = BCW'(NB - 1);
         byte_valid_d = 1'b1;
      end else if (xfer) begin
         if (last_byte) begin
            byte_valid_d = 1'b0;
         end else begin
            shift_d      = shift_q << 8;
            bytes_left_d = bytes_left_q - BCW'(1);
         end
      end
   end

   assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= IDLE;
         cic_prev_q   <= 1'b1;
         count_q      <= '0;
         edge_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         shift_q      <= '0;
         bytes_left_q <= '0;
         byte_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cic_prev_q   <= cic_clk_i;
         count_q      <= count_d;
         edge_cnt_q   <= edge_cnt_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         shift_q      <= shift_d;
         bytes_left_q <= bytes_left_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   // Storage array needs no reset; pointers define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= sample_i;
   end

   assign byte_o       = byte_valid_q ? shift_q[SW-1 -: 8] : 8'h00;
   assign byte_valid_o = byte_valid_q;
   assign busy_o       = (state_q != IDLE);
   assign overflow_o   = overflow_q;
   assign done_o       = done;

endmodule

// File: tb/tb_cic_sample_sequencer.sv
// Directed bench for cic_sample_sequencer: a byte-queue model checked every cycle,
// plus literal expectations per scenario.
module tb_cic_sample_sequencer;

   localparam int NB    = 3;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cic;
   logic [19:0] sample;
   logic        start, stop;
   logic [7:0]  cnt;
   logic [7:0]  dut_byte;
   logic        dut_valid;
   logic        ready;
   logic        dut_busy, dut_ovf, dut_done;

   cic_sample_sequencer dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .cic_clk_i      (cic),
      .sample_i       (sample),
      .start_i        (start),
      .stop_i         (stop),
      .capture_count_i(cnt),
      .byte_o         (dut_byte),
      .byte_valid_o   (dut_valid),
      .byte_ready_i   (ready),
      .busy_o         (dut_busy),
      .overflow_o     (dut_ovf),
      .done_o         (dut_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int         mode_m = 0;  // 0 idle, 1 capturing, 2 draining
   int         cnt_m, edges_m, cyc;
   bit         ovf_m;
   bit         prev_m = 1'b1;
   logic [7:0] q[$];
   logic [7:0] rx_log[$];
   int         done_cnt = 0;
   int         last_lat = -1;
   int         lat_edge;
   bit         lat_pend = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_byte", 32'(dut_byte), 32'd0);
         chk("rst_valid", 32'(dut_valid), 32'd0);
         chk("rst_busy", 32'(dut_busy), 32'd0);
         chk("rst_ovf", 32'(dut_ovf), 32'd0);
         chk("rst_done", 32'(dut_done), 32'd0);
         mode_m   = 0;
         ovf_m    = 1'b0;
         prev_m   = 1'b1;
         lat_pend = 1'b0;
         q.delete();
      end else begin
         bit   done_exp, xfer, lastx, edge_m, allowed;
         int   held;
         logic [23:0] s24;
         cyc++;
         done_exp = (mode_m == 2) && (q.size() == 0);
         chk("busy", 32'(dut_busy), 32'(mode_m != 0));
         chk("overflow", 32'(dut_ovf), 32'(ovf_m));
         chk("done", 32'(dut_done), 32'(done_exp));
         if (dut_done) done_cnt++;
         if (dut_valid) begin
            if (q.size() == 0) chk("spurious_valid", 32'(dut_valid), 32'd0);
            else chk("byte", 32'(dut_byte), 32'(q[0]));
            if (lat_pend) begin
               last_lat = cyc - lat_edge;
               lat_pend = 1'b0;
            end
         end
         xfer  = dut_valid && ready && (q.size() > 0);
         lastx = xfer && (q.size() % NB == 1);
         held  = (q.size() + NB - 1) / NB;
         edge_m = cic && !prev_m;
         prev_m = cic;
         if (xfer) rx_log.push_back(q.pop_front());
         case (mode_m)
            0: if (start) begin
               mode_m = 1; cnt_m = int'(cnt); edges_m = 0; ovf_m = 1'b0;
            end
            1: begin
               if (edge_m) begin
                  edges_m++;
                  allowed = (held < DEPTH + 1) || (held == DEPTH + 1 && lastx);
                  if (allowed) begin
                     if (q.size() == 0 && !dut_valid) begin
                        lat_edge = cyc; lat_pend = 1'b1;
                     end
                     s24 = {4'h0, sample};
                     for (int b = NB - 1; b >= 0; b--) q.push_back(s24[8*b +: 8]);
                  end else begin
                     ovf_m = 1'b1;
                  end
                  if (cnt_m != 0 && edges_m == cnt_m) mode_m = 2;
               end
               if (stop) mode_m = 2;
            end
            default: if (done_exp) mode_m = 0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] c);
      start = 1'b1; cnt = c;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse(input logic [19:0] d, input int hi, input int lo);
      sample = d; cic = 1'b1;
      repeat (hi) tick();
      cic = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!dut_busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic chk_bytes(input string name, input int base, input logic [7:0] e[$]);
      chk({name, "_len"}, 32'(rx_log.size() - base), 32'(e.size()));
      for (int i = 0; i < e.size(); i++)
         chk({name, "_b"}, (base + i < rx_log.size()) ? 32'(rx_log[base + i]) : 32'hFFFF,
             32'(e[i]));
   endtask

   initial begin
      int nv, base, d0;
      logic [7:0] e[$];
      rstn = 1'b0; cic = 1'b1; sample = '0; start = 1'b0; stop = 1'b0; cnt = '0; ready = 1'b1;
      repeat (3) tick();

      // Reset released with the CIC clock already high: no edge, nothing happens.
      rstn = 1'b1;
      nv = 0;
      repeat (50) begin
         tick();
         if (dut_valid || dut_busy || dut_ovf || dut_done) nv++;
      end
      chk("s1_quiet", 32'(nv), 32'd0);
      cic = 1'b0;
      repeat (3) tick();

      // Two-sample window, consumer always ready.
      base = rx_log.size(); d0 = done_cnt; last_lat = -1;
      do_start(8'd2);
      pulse(20'hABCDE, 3, 7);
      pulse(20'h12345, 3, 7);
      wait_idle("s2", 100);
      e = '{8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
      chk_bytes("s2", base, e);
      chk("s2_latency", 32'(last_lat), 32'd2);
      chk("s2_done", 32'(done_cnt - d0), 32'd1);
      chk("s2_ovf", 32'(dut_ovf), 32'd0);
      chk("s2_q", 32'(q.size()), 32'd0);

      // Six edges with the consumer stalled: five fit, the sixth is dropped.
      base = rx_log.size(); d0 = done_cnt;
      ready = 1'b0;
      do_start(8'd6);
      for (int i = 1; i <= 6; i++) pulse(20'h11111 * 20'(i), 2, 3);
      chk("s3_ovf_early", 32'(dut_ovf), 32'd1);
      ready = 1'b1;
      wait_idle("s3", 200);
      chk("s3_len", 32'(rx_log.size() - base), 32'd15);
      e = '{8'h05, 8'h55, 8'h55};
      chk_bytes("s3_tail", rx_log.size() - 3, e);
      chk("s3_ovf", 32'(dut_ovf), 32'd1);
      chk("s3_done", 32'(done_cnt - d0), 32'd1);
      repeat (5) tick();
      chk("s3_ovf_sticky", 32'(dut_ovf), 32'd1);

      // Continuous mode, stop coincident with the third edge; fourth edge arrives in drain.
      base = rx_log.size(); d0 = done_cnt;
      do_start(8'd0);
      chk("s4_ovf_cleared", 32'(dut_ovf), 32'd0);
      pulse(20'h00A01, 3, 7);
      pulse(20'hB0B02, 3, 7);
      sample = 20'hC0C03; cic = 1'b1; stop = 1'b1;
      tick();
      stop = 1'b0;
      tick(); tick();
      cic = 1'b0; ready = 1'b0;
      repeat (7) tick();
      pulse(20'hDDDDD, 3, 2);
      ready = 1'b1;
      wait_idle("s4", 100);
      e = '{8'h00, 8'h0A, 8'h01, 8'h0B, 8'h0B, 8'h02, 8'h0C, 8'h0C, 8'h03};
      chk_bytes("s4", base, e);
      chk("s4_done", 32'(done_cnt - d0), 32'd1);

      // Asynchronous reset while draining with a byte on the bus.
      d0 = done_cnt;
      ready = 1'b0;
      do_start(8'd3);
      pulse(20'h77777, 2, 3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("s5_pre_valid", 32'(dut_valid), 32'd1);
      rstn = 1'b0;
      #1;
      chk("s5_byte", 32'(dut_byte), 32'd0);
      chk("s5_valid", 32'(dut_valid), 32'd0);
      chk("s5_busy", 32'(dut_busy), 32'd0);
      chk("s5_done_now", 32'(dut_done), 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      ready = 1'b1;
      tick();
      base = rx_log.size();
      do_start(8'd1);
      pulse(20'h2468A, 3, 7);
      wait_idle("s5", 100);
      e = '{8'h02, 8'h46, 8'h8A};
      chk_bytes("s5", base, e);
      chk("s5_ovf", 32'(dut_ovf), 32'd0);
      chk("s5_done", 32'(done_cnt - d0), 32'd1);

      // A start during capture with a different count must be ignored.
      base = rx_log.size(); d0 = done_cnt;
      do_start(8'd2);
      pulse(20'h11111, 3, 3);
      do_start(8'd5);
      repeat (3) tick();
      pulse(20'h22222, 3, 7);
      wait_idle("s6", 100);
      pulse(20'h33333, 3, 7);
      e = '{8'h01, 8'h11, 8'h11, 8'h02, 8'h22, 8'h22};
      chk_bytes("s6", base, e);
      chk("s6_done", 32'(done_cnt - d0), 32'd1);
      chk("s6_busy", 32'(dut_busy), 32'd0);
      chk("s6_q", 32'(q.size()), 32'd0);

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
